branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised dynamic branch predictor for the 5-stage pipelined CPU.
- IF side: looks up the fetch PC every cycle and returns a taken/not-taken prediction plus a predicted target, so the PC mux can redirect fetch without waiting for ID.
- ID side: when the ID-stage branch unit resolves a branch, its outcome trains the predictor.
- Structure: a direct-mapped table of ENTRIES lines, each holding a valid bit, a tag, a branch target and a saturating counter of width CNT_W.
- Replaces the fixed predict-not-taken and flush behaviour of the current core.

## Interface
Parameters
- ENTRIES, 64: table lines; power of two, ≥ 4. IDX_W = log2(ENTRIES).
- CNT_W, 2: saturating counter width, 1–4.
- TAG_W, 8: tag bits per line; IDX_W + TAG_W + 2 ≤ 32.
- GHR_W, 6: global history length; ≤ IDX_W. Used only under BP_GSHARE_EN.

Ports
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk_i  in  1  clock.
  - rst_i  in  1  synchronous, active-high reset.
- IF-side lookup:
  - pc_i  in  32  IF fetch PC.
  - pred_hit_o  out  1  valid line whose tag matches pc_i.
  - pred_taken_o  out  1  predict taken; equals pred_hit_o AND counter MSB.
  - pred_target_o  out  32  stored target; 0 when pred_hit_o=0.
  - pred_idx_o  out  IDX_W  counter index used for this lookup; the pipeline carries it to ID.
- ID-side update:
  - upd_valid_i  in  1  a resolved conditional branch is in ID this cycle.
  - upd_pc_i  in  32  PC of the resolved branch.
  - upd_idx_i  in  IDX_W  pred_idx_o value captured at that branch's fetch.
  - upd_taken_i  in  1  actual outcome.
  - upd_target_i  in  32  branch target computed in ID.

## Operation
Index and tag
- Line index L = pc[IDX_W+1:2].
- Tag T = pc[IDX_W+TAG_W+1:IDX_W+2].
- Counter index C = L, or L XOR ghr (GHR zero-extended to IDX_W) under BP_GSHARE_EN.
- The counter array and the line array are separate, both with ENTRIES entries.

Lookup
- Purely combinational from registered state.
- pred_hit_o = valid[L] && tag[L]==T.
- No bypass: a same-cycle update is not visible to the lookup.

Update (clock edge with upd_valid_i=1; L and T taken from upd_pc_i; counter index = upd_idx_i under BP_GSHARE_EN, else L)
- Hit (valid and tag match):
  - Counter increments on taken and decrements on not-taken, saturating at 2^CNT_W−1 and 0.
  - target[L] is written with upd_target_i only when taken.
- Miss:
  - Line is allocated: valid=1, tag=T, target=upd_target_i.
  - Counter initialised to weak-taken (2^(CNT_W−1)) if taken, else weak-not-taken (2^(CNT_W−1)−1).
  - CNT_W=1: initialised to upd_taken_i.
- Under BP_GSHARE_EN: ghr <= {ghr[GHR_W−2:0], upd_taken_i}.
- upd_valid_i=0: no state change.

Reset
- All valid bits 0.
- All counters weak-not-taken.
- ghr 0.
- Outputs follow from this state: pred_hit_o=0, pred_taken_o=0, pred_target_o=0.
- pred_idx_o = L, since ghr=0.

## Timing
- Lookup latency 0 cycles (combinational). An update at edge k is visible to a lookup from cycle k+1 onward.
- One update per cycle maximum. Lookup and update are concurrent and independent.
- rst_i has priority over upd_valid_i on the same edge. A reset asserted mid-run clears all lines at that edge; the first valid lookup is the cycle after rst_i falls.
- Aliasing on line index: the newer tag overwrites, with no associativity.
- Aliasing on counter index in gshare mode: the counter is shared and not tag-checked.

## Configuration
- BP_GSHARE_EN defined:
  - Counter index = PC index XOR global history.
  - GHR register present; upd_idx_i used.
- BP_GSHARE_EN undefined:
  - Pure bimodal predictor; counter index = L.
  - No GHR; upd_idx_i ignored; pred_idx_o = L.
- Tag, target and valid arrays behave identically in both builds.

## Test plan
All cases use default parameters.
- Reset state: pulse rst_i, then pc_i=0x100 → pred_hit_o=0, pred_taken_o=0, pred_target_o=0.
- Allocation: update pc=0x100, taken, target 0x80; next cycle pc_i=0x100 → hit=1, taken=1, target=0x80 (counter=2).
- Saturation:
  - Two not-taken updates on 0x100 → taken=0 (counter 0); a third keeps counter at 0.
  - Then four taken updates → counter 3, taken=1; a fifth keeps counter at 3.
- Tag conflict: allocate 0x100 (target 0x80), then update 0x4100 (same L, different tag), taken, target 0x40 → lookup 0x100 gives hit=0; lookup 0x4100 gives hit=1, target 0x40.
- Same-cycle and reset:
  - Lookup 0x100 on the same edge as its first allocation → hit=0 that cycle, hit=1 the next.
  - rst_i asserted with upd_valid_i=1 → line not allocated; hit=0 afterwards.
- Gshare (BP_GSHARE_EN only): three taken updates → ghr=0b000111; pc_i=0x100 → pred_idx_o=0x07.

Source files
------------

// File: rtl/branch_predictor.sv
// Purpose : direct-mapped dynamic branch predictor. IF looks up the fetch PC, ID trains on resolved branches.
// Latency : lookup is combinational (0 cycles); an update on edge k is visible to lookups from cycle k+1.
// Backpressure: none; one lookup and at most one update every cycle, both always accepted.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   pc_i                         IF fetch PC to look up
//   pred_hit_o/pred_taken_o      valid tag match / predict taken (hit AND counter MSB)
//   pred_target_o                stored target, 0 on miss
//   pred_idx_o                   counter index used for this lookup, carried down the pipe to ID
//   upd_valid_i/upd_pc_i         resolved conditional branch in ID and its PC
//   upd_idx_i                    pred_idx_o captured at that branch's fetch (gshare build only)
//   upd_taken_i/upd_target_i     actual outcome and computed target
//
// Build option: define BP_GSHARE_EN to XOR a global history register into the counter
// index (gshare). Left undefined, the predictor is purely bimodal and upd_idx_i is ignored.
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 2,
    parameter int TAG_W   = 8,
    parameter int GHR_W   = 6,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      pc_i,
    output logic             pred_hit_o,
    output logic             pred_taken_o,
    output logic [31:0]      pred_target_o,
    output logic [IDX_W-1:0] pred_idx_o,
    input  logic             upd_valid_i,
    input  logic [31:0]      upd_pc_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i,
    input  logic [31:0]      upd_target_i
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << CNT_W) - 1);
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);

    // Line arrays (valid/tag/target) and counter array are indexed independently.
    logic              r_valid  [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [31:0]       r_target [ENTRIES];
    logic [CNT_W-1:0]  r_cnt    [ENTRIES];

    logic [IDX_W-1:0]  w_look_l;
    logic [TAG_W-1:0]  w_look_t;
    logic [IDX_W-1:0]  w_look_c;
    logic              w_look_hit;

    logic [IDX_W-1:0]  w_upd_l;
    logic [TAG_W-1:0]  w_upd_t;
    logic [IDX_W-1:0]  w_upd_c;
    logic              w_upd_hit;
    logic [CNT_W-1:0]  w_cnt_cur;
    logic [CNT_W-1:0]  w_cnt_nxt;

    assign w_look_l = pc_i[IDX_W+1:2];
    assign w_look_t = pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign w_upd_l  = upd_pc_i[IDX_W+1:2];
    assign w_upd_t  = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] r_ghr;

    assign w_look_c = w_look_l ^ IDX_W'(r_ghr);
    // The counter used at fetch is replayed exactly; the GHR may have moved on since.
    assign w_upd_c  = upd_idx_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ghr <= '0;
        end else if (upd_valid_i) begin
            r_ghr <= (r_ghr << 1) | GHR_W'(upd_taken_i);
        end
    end

    logic w_unused_bits;
    assign w_unused_bits = ^{pc_i[31:IDX_W+TAG_W+2], pc_i[1:0],
                             upd_pc_i[31:IDX_W+TAG_W+2], upd_pc_i[1:0]};
`else
    assign w_look_c = w_look_l;
    assign w_upd_c  = w_upd_l;

    logic w_unused_bits;
    assign w_unused_bits = ^{pc_i[31:IDX_W+TAG_W+2], pc_i[1:0],
                             upd_pc_i[31:IDX_W+TAG_W+2], upd_pc_i[1:0], upd_idx_i};
`endif

    // Lookup: pure read of registered state, so a same-cycle update is never bypassed.
    assign w_look_hit    = r_valid[w_look_l] && (r_tag[w_look_l] == w_look_t);
    assign pred_hit_o    = w_look_hit;
    assign pred_taken_o  = w_look_hit && r_cnt[w_look_c][CNT_W-1];
    assign pred_target_o = w_look_hit ? r_target[w_look_l] : 32'd0;
    assign pred_idx_o    = w_look_c;

    assign w_upd_hit = r_valid[w_upd_l] && (r_tag[w_upd_l] == w_upd_t);
    assign w_cnt_cur = r_cnt[w_upd_c];

    // Hit: saturating step. Miss: restart at the weak state on the side of the outcome
    // (for a 1-bit counter this reduces to the outcome itself).
    always_comb begin
        w_cnt_nxt = w_cnt_cur;
        if (w_upd_hit) begin
            if (upd_taken_i && (w_cnt_cur != CNT_MAX)) begin
                w_cnt_nxt = w_cnt_cur + 1'b1;
            end else if (!upd_taken_i && (w_cnt_cur != '0)) begin
                w_cnt_nxt = w_cnt_cur - 1'b1;
            end
        end else begin
            w_cnt_nxt = upd_taken_i ? CNT_WT : CNT_WNT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_cnt[i]   <= CNT_WNT;
            end
        end else if (upd_valid_i) begin
            r_valid[w_upd_l] <= 1'b1;
            r_cnt[w_upd_c]   <= w_cnt_nxt;
        end
    end

    // Tag/target need no reset: they are only observed through a set valid bit.
    always_ff @(posedge clk_i) begin
        if (!rst_i && upd_valid_i) begin
            if (!w_upd_hit) begin
                r_tag[w_upd_l]    <= w_upd_t;
                r_target[w_upd_l] <= upd_target_i;
            end else if (upd_taken_i) begin
                r_target[w_upd_l] <= upd_target_i;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    localparam int IDX_W = 6;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [31:0]      pc_i;
    logic             pred_hit_o;
    logic             pred_taken_o;
    logic [31:0]      pred_target_o;
    logic [IDX_W-1:0] pred_idx_o;
    logic             upd_valid_i;
    logic [31:0]      upd_pc_i;
    logic [IDX_W-1:0] upd_idx_i;
    logic             upd_taken_i;
    logic [31:0]      upd_target_i;

    int n_tests = 0;
    int n_fail  = 0;

    branch_predictor dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pc_i         (pc_i),
        .pred_hit_o   (pred_hit_o),
        .pred_taken_o (pred_taken_o),
        .pred_target_o(pred_target_o),
        .pred_idx_o   (pred_idx_o),
        .upd_valid_i  (upd_valid_i),
        .upd_pc_i     (upd_pc_i),
        .upd_idx_i    (upd_idx_i),
        .upd_taken_i  (upd_taken_i),
        .upd_target_i (upd_target_i)
    );

    always #5 clk_i = ~clk_i;

    // One row = inputs held for one cycle; expectations are the outputs seen
    // during that cycle, i.e. before the row's own update takes effect.
    typedef struct {
        logic        rst;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic [31:0] pc;
        logic        e_hit;
        logic        e_tkn;
        logic [31:0] e_tgt;
        logic [5:0]  e_idx;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got 0x%0h, expected 0x%0h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt, input logic [31:0] pc, input logic eh,
                       input logic et, input logic [31:0] etg, input logic [5:0] ei);
        vec_t v;
        v.rst = rst; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
        v.pc = pc; v.e_hit = eh; v.e_tkn = et; v.e_tgt = etg; v.e_idx = ei;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic uv, input logic [31:0] upc,
                         input logic [5:0] uidx, input logic ut, input logic [31:0] utgt,
                         input logic [31:0] pc);
        @(negedge clk_i);
        rst_i = rst; upd_valid_i = uv; upd_pc_i = upc; upd_idx_i = uidx;
        upd_taken_i = ut; upd_target_i = utgt; pc_i = pc;
        #1;
    endtask

    initial begin
        rst_i = 1'b1; pc_i = 32'h100; upd_valid_i = 1'b0; upd_pc_i = '0;
        upd_idx_i = '0; upd_taken_i = 1'b0; upd_target_i = '0;
        repeat (2) @(posedge clk_i);

`ifndef BP_GSHARE_EN
        //   rst uv  upc        ut  utgt        pc         hit tkn tgt        idx
        add(0, 0, 32'h0,    0, 32'h0,   32'h100,  0, 0, 32'h0,   6'd0); // reset state
        add(0, 1, 32'h100,  1, 32'h80,  32'h100,  0, 0, 32'h0,   6'd0); // alloc, no bypass
        add(0, 0, 32'h0,    0, 32'h0,   32'h100,  1, 1, 32'h80,  6'd0); // cnt 2
        add(0, 1, 32'h100,  0, 32'h999, 32'h100,  1, 1, 32'h80,  6'd0); // NT: target kept
        add(0, 1, 32'h100,  0, 32'h0,   32'h100,  1, 0, 32'h80,  6'd0); // cnt 1
        add(0, 1, 32'h100,  0, 32'h0,   32'h100,  1, 0, 32'h80,  6'd0); // cnt 0, stays 0
        add(0, 1, 32'h100,  1, 32'h80,  32'h100,  1, 0, 32'h80,  6'd0); // cnt 0 (no wrap)
        add(0, 1, 32'h100,  1, 32'h200, 32'h100,  1, 0, 32'h80,  6'd0); // cnt 1
        add(0, 1, 32'h100,  1, 32'h200, 32'h100,  1, 1, 32'h200, 6'd0); // cnt 2, new target
        add(0, 1, 32'h100,  1, 32'h200, 32'h100,  1, 1, 32'h200, 6'd0); // cnt 3
        add(0, 1, 32'h100,  1, 32'h200, 32'h100,  1, 1, 32'h200, 6'd0); // 5th taken
        add(0, 1, 32'h100,  0, 32'h0,   32'h100,  1, 1, 32'h200, 6'd0); // still 3
        add(0, 1, 32'h100,  0, 32'h0,   32'h100,  1, 1, 32'h200, 6'd0); // cnt 2
        add(0, 0, 32'h0,    0, 32'h0,   32'h100,  1, 0, 32'h200, 6'd0); // cnt 1
        add(0, 1, 32'h4100, 1, 32'h40,  32'h100,  1, 0, 32'h200, 6'd0); // tag conflict
        add(0, 0, 32'h0,    0, 32'h0,   32'h100,  0, 0, 32'h0,   6'd0); // old tag evicted
        add(0, 0, 32'h0,    0, 32'h0,   32'h4100, 1, 1, 32'h40,  6'd0); // new tag, weak taken
        add(0, 1, 32'h104,  0, 32'h300, 32'h104,  0, 0, 32'h0,   6'd1); // alloc line 1 NT
        add(0, 0, 32'h0,    0, 32'h0,   32'h104,  1, 0, 32'h300, 6'd1); // weak NT
        add(0, 0, 32'h0,    0, 32'h0,   32'h4100, 1, 1, 32'h40,  6'd0); // line 0 untouched
        add(1, 1, 32'h208,  1, 32'h55,  32'h4100, 1, 1, 32'h40,  6'd0); // reset beats update
        add(0, 0, 32'h0,    0, 32'h0,   32'h208,  0, 0, 32'h0,   6'd2); // not allocated
        add(0, 0, 32'h0,    0, 32'h0,   32'h4100, 0, 0, 32'h0,   6'd0); // cleared
        add(0, 0, 32'h0,    0, 32'h0,   32'h104,  0, 0, 32'h0,   6'd1); // cleared

        for (int r = 0; r < vecs.size(); r++) begin
            drive(vecs[r].rst, vecs[r].uv, vecs[r].upc, 6'd0, vecs[r].ut, vecs[r].utgt, vecs[r].pc);
            check("hit",    r, {31'd0, pred_hit_o},   {31'd0, vecs[r].e_hit});
            check("taken",  r, {31'd0, pred_taken_o}, {31'd0, vecs[r].e_tkn});
            check("target", r, pred_target_o,         vecs[r].e_tgt);
            check("idx",    r, {26'd0, pred_idx_o},   {26'd0, vecs[r].e_idx});
        end
`else
        // Three taken updates shift 0b000111 into the history; lookup index = L(0) ^ ghr.
        drive(0, 0, 32'h0, 6'd0, 0, 32'h0, 32'h100);
        check("gs_idx_reset", 0, {26'd0, pred_idx_o}, 32'd0);
        drive(0, 1, 32'h100, 6'd0, 1, 32'h80, 32'h100);
        check("gs_idx_h0", 1, {26'd0, pred_idx_o}, 32'd0);
        drive(0, 1, 32'h100, 6'd0, 1, 32'h80, 32'h100);
        check("gs_idx_h1", 2, {26'd0, pred_idx_o}, 32'd1);
        drive(0, 1, 32'h100, 6'd0, 1, 32'h80, 32'h100);
        check("gs_idx_h3", 3, {26'd0, pred_idx_o}, 32'd3);
        drive(0, 0, 32'h0, 6'd0, 0, 32'h0, 32'h100);
        check("gs_idx_h7", 4, {26'd0, pred_idx_o}, 32'd7);
        check("gs_hit",    4, {31'd0, pred_hit_o}, 32'd1);
        check("gs_target", 4, pred_target_o, 32'h80);
        // Counter 7 was still weak-not-taken from reset.
        check("gs_taken",  4, {31'd0, pred_taken_o}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
